// File: rtl/adc_trigger_ctrl.sv
// ADC acquisition trigger controller: decimates incoming samples, fills a pretrigger
// window, detects a trigger event and streams samples to a downstream capture FIFO.
//
// state     | meaning
// IDLE      | after reset, waiting for arm
// PRETRIG   | streaming, collecting pretrigger samples; triggers not honoured
// WAIT_TRIG | streaming, evaluating the trigger on each accepted sample
// CAPTURE   | streaming post-trigger samples until the FIFO reports done
// DONE      | capture complete, no writes until the next arm
module adc_trigger_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int DEC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  adc_valid,
  input  logic                  arm,
  input  logic                  sw_trig,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic [DEC_WIDTH-1:0]  decimate,
  input  logic [31:0]           pretrig_depth,
  input  logic                  fifo_done,
  output logic                  fifo_rst,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ce,
  output logic                  wr_trigger,
  output logic [31:0]           trig_pos,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                state;
  logic [DEC_WIDTH-1:0]  dec_cnt;
  logic [31:0]           acc_cnt;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_valid;
  logic                  sw_latch;

  logic active;
  logic accept;
  logic cur_above;
  logic prev_above;
  logic hit;

  assign active     = (state == PRETRIG) || (state == WAIT_TRIG) || (state == CAPTURE);
  assign accept     = active && adc_valid && (dec_cnt == '0);
  assign cur_above  = (adc_data >= trig_level);
  assign prev_above = (prev >= trig_level);

  // Trigger condition for the sample being accepted this cycle.
  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      2'b00:   hit = sw_latch;
      2'b01:   hit = prev_valid && !prev_above && cur_above;
      2'b10:   hit = prev_valid && prev_above && !cur_above;
      default: hit = cur_above;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dec_cnt    <= '0;
      acc_cnt    <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      sw_latch   <= 1'b0;
      fifo_rst   <= 1'b0;
      wr_data    <= '0;
      wr_ce      <= 1'b0;
      wr_trigger <= 1'b0;
      trig_pos   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (arm) begin
      state      <= (pretrig_depth == 32'd0) ? WAIT_TRIG : PRETRIG;
      dec_cnt    <= '0;
      acc_cnt    <= '0;
      prev_valid <= 1'b0;
      sw_latch   <= 1'b0;
      fifo_rst   <= 1'b1;
      wr_ce      <= 1'b0;
      wr_trigger <= 1'b0;
      trig_pos   <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      fifo_rst   <= 1'b0;
      wr_trigger <= 1'b0;
      wr_ce      <= accept;
      if (accept) begin
        wr_data    <= adc_data;
        prev       <= adc_data;
        prev_valid <= 1'b1;
        if (acc_cnt != 32'hFFFF_FFFF) acc_cnt <= acc_cnt + 32'd1;
      end
      if (active && adc_valid) begin
        dec_cnt <= (dec_cnt == '0) ? decimate : dec_cnt - DEC_WIDTH'(1);
      end

      case (state)
        IDLE: ;
        PRETRIG: begin
          // acc_cnt is registered, so the switch lands one cycle after the target is reached
          if (acc_cnt >= pretrig_depth) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (accept && hit) begin
            state      <= CAPTURE;
            wr_trigger <= 1'b1;
            trig_pos   <= acc_cnt;
            if (trig_mode == 2'b00) sw_latch <= 1'b0;
          end else if (sw_trig) begin
            sw_latch <= 1'b1;
          end
        end
        CAPTURE: begin
          if (fifo_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: ;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
